// File: rtl/branch_target_unit.sv
// branch_target_unit
// Two-stage control-transfer target unit for JAL, JALR and conditional
// branches. Stage 1 registers the request operands; stage 2 registers the
// computed target, link address, taken flag and fault flags, which drive the
// outputs directly. Both stages share one advance condition, so a full pipe
// with the consumer ready accepts a new request every cycle without a bubble.
module branch_target_unit #(
  parameter int WORD_SIZE  = 32,
  parameter int IMM_WIDTH  = 21,
  parameter int COMPRESSED = 0
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [1:0]           mode,
  input  logic [2:0]           funct3,
  input  logic [WORD_SIZE-1:0] pc,
  input  logic [WORD_SIZE-1:0] rs1,
  input  logic [WORD_SIZE-1:0] rs2,
  input  logic [IMM_WIDTH-1:0] imm,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WORD_SIZE-1:0] target,
  output logic [WORD_SIZE-1:0] link,
  output logic                 taken,
  output logic                 misaligned,
  output logic                 illegal
);

  localparam logic [1:0] MODE_JAL    = 2'b00;
  localparam logic [1:0] MODE_JALR   = 2'b01;
  localparam logic [1:0] MODE_BRANCH = 2'b10;

  localparam logic [2:0] F3_EQ  = 3'b000;
  localparam logic [2:0] F3_NE  = 3'b001;
  localparam logic [2:0] F3_LT  = 3'b100;
  localparam logic [2:0] F3_GE  = 3'b101;
  localparam logic [2:0] F3_LTU = 3'b110;
  localparam logic [2:0] F3_GEU = 3'b111;

  localparam logic [WORD_SIZE-1:0] LINK_STEP = WORD_SIZE'(4);
  localparam logic [WORD_SIZE-1:0] JALR_MASK = {{(WORD_SIZE-1){1'b1}}, 1'b0};

  // Stage 1 request registers
  logic                 s1_valid;
  logic [1:0]           s1_mode;
  logic [2:0]           s1_funct3;
  logic [WORD_SIZE-1:0] s1_pc;
  logic [WORD_SIZE-1:0] s1_rs1;
  logic [WORD_SIZE-1:0] s1_rs2;
  logic [IMM_WIDTH-1:0] s1_imm;

  // Stage 1 combinational results
  logic [WORD_SIZE-1:0] imm_ext;
  logic [WORD_SIZE-1:0] pc_target;
  logic [WORD_SIZE-1:0] rs1_target;
  logic                 cond_eq;
  logic                 cond_lt;
  logic                 cond_ltu;
  logic                 cond_true;
  logic                 funct3_rsvd;
  logic [WORD_SIZE-1:0] nxt_target;
  logic [WORD_SIZE-1:0] nxt_link;
  logic                 nxt_taken;
  logic                 nxt_misaligned;
  logic                 nxt_illegal;

  // Pipeline handshake
  logic s2_load;
  logic accept;

  // S2 is free when empty or being drained; S1 advances on the same condition.
  assign s2_load  = !out_valid || out_ready;
  assign in_ready = reset_n && (!s1_valid || s2_load);
  assign accept   = in_valid && in_ready;

  // Stage 1 valid bit: flush kills, new request fills, drain empties.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_valid <= 1'b0;
    end else if (flush) begin
      s1_valid <= 1'b0;
    end else if (accept) begin
      s1_valid <= 1'b1;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 1 operand capture on acceptance; data survives a flush untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1_mode   <= 2'b00;
      s1_funct3 <= 3'b000;
      s1_pc     <= '0;
      s1_rs1    <= '0;
      s1_rs2    <= '0;
      s1_imm    <= '0;
    end else if (accept) begin
      s1_mode   <= mode;
      s1_funct3 <= funct3;
      s1_pc     <= pc;
      s1_rs1    <= rs1;
      s1_rs2    <= rs2;
      s1_imm    <= imm;
    end
  end

  // Target arithmetic and branch condition evaluation on stage 1 operands.
  always_comb begin
    imm_ext    = WORD_SIZE'($signed(s1_imm));
    pc_target  = s1_pc + imm_ext;
    rs1_target = (s1_rs1 + imm_ext) & JALR_MASK;
    cond_eq    = (s1_rs1 == s1_rs2);
    cond_lt    = ($signed(s1_rs1) < $signed(s1_rs2));
    cond_ltu   = (s1_rs1 < s1_rs2);

    cond_true   = 1'b0;
    funct3_rsvd = 1'b0;
    case (s1_funct3)
      F3_EQ:   cond_true = cond_eq;
      F3_NE:   cond_true = !cond_eq;
      F3_LT:   cond_true = cond_lt;
      F3_GE:   cond_true = !cond_lt;
      F3_LTU:  cond_true = cond_ltu;
      F3_GEU:  cond_true = !cond_ltu;
      default: funct3_rsvd = 1'b1;
    endcase
  end

  // Result selection by mode; illegal requests never redirect or fault.
  always_comb begin
    nxt_link    = s1_pc + LINK_STEP;
    nxt_target  = pc_target;
    nxt_taken   = 1'b0;
    nxt_illegal = 1'b0;
    case (s1_mode)
      MODE_JAL: begin
        nxt_target = pc_target;
        nxt_taken  = 1'b1;
      end
      MODE_JALR: begin
        nxt_target = rs1_target;
        nxt_taken  = 1'b1;
      end
      MODE_BRANCH: begin
        nxt_target  = pc_target;
        nxt_illegal = funct3_rsvd;
        nxt_taken   = cond_true && !funct3_rsvd;
      end
      default: begin
        nxt_target  = pc_target;
        nxt_illegal = 1'b1;
        nxt_taken   = 1'b0;
      end
    endcase

    // Only a redirect that actually happens can fault on alignment.
    if (COMPRESSED != 0) begin
      nxt_misaligned = nxt_taken && nxt_target[0];
    end else begin
      nxt_misaligned = nxt_taken && (|nxt_target[1:0]);
    end
  end

  // Stage 2 valid bit: flush overrides the consumer handshake.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (s2_load) begin
      out_valid <= s1_valid;
    end
  end

  // Stage 2 result registers; held stable while the consumer stalls.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      target     <= '0;
      link       <= '0;
      taken      <= 1'b0;
      misaligned <= 1'b0;
      illegal    <= 1'b0;
    end else if (s2_load && s1_valid) begin
      target     <= nxt_target;
      link       <= nxt_link;
      taken      <= nxt_taken;
      misaligned <= nxt_misaligned;
      illegal    <= nxt_illegal;
    end
  end

endmodule
